// File: rtl/sfifo_pkg.sv
// sfifo_pkg
// Shared helpers for the single-clock stream FIFO:
//   clog2            - address width needed for a given number of entries
//   RAM_AUTO/BLOCK/DISTRIBUTED - accepted values for the ram_style hint
package sfifo_pkg;

  localparam string RAM_AUTO        = "auto";
  localparam string RAM_BLOCK       = "block";
  localparam string RAM_DISTRIBUTED = "distributed";

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// sfifo_mem
// DATASIZE x DEPTH storage array, synchronous write, asynchronous read.
// The array has no reset: stale words are harmless because the pointers
// in the parent decide what is valid.
// Ports:
//   clk       rising-edge clock
//   wclken_i  write enable
//   waddr_i   write address
//   wdata_i   write data
//   raddr_i   read address (combinational read)
//   rdata_o   read data
module sfifo_mem
  import sfifo_pkg::*;
#(
  parameter int    DATASIZE = 32,
  parameter int    DEPTH    = 16,
  parameter string RAM_TYPE = RAM_DISTRIBUTED,
  localparam int   AW       = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wclken_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);

  (* ram_style = RAM_TYPE *) logic [DATASIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wclken_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sfifo_stream.sv
// sfifo_stream
// Single-clock stream FIFO with valid/ready on both sides, occupancy count,
// almost-full/almost-empty flags, synchronous flush and an optional
// first-word-fall-through output register (OUT_REG=1 adds one slot).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      synchronous clear, beats push and pop
//   in_data/in_valid/in_ready  write side
//   out_data/out_valid/out_ready read side
//   count                      words held, output register included
//   almost_full/almost_empty   threshold flags decoded from count
module sfifo_stream
  import sfifo_pkg::*;
#(
  parameter int    DATASIZE     = 32,
  parameter int    ADDRSIZE     = 4,
  parameter string RAM_TYPE     = RAM_DISTRIBUTED,
  parameter int    OUT_REG      = 0,
  parameter int    AFULL_LEVEL  = (1 << ADDRSIZE) - 2,
  parameter int    AEMPTY_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [DATASIZE-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDRSIZE:0]   count,
  output logic                almost_full,
  output logic                almost_empty
);

  localparam logic [ADDRSIZE:0] PTR_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [ADDRSIZE:0] AFULL_L  = AFULL_LEVEL[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AEMPTY_L = AEMPTY_LEVEL[ADDRSIZE:0];

  logic [ADDRSIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic                arr_empty, arr_full, push, pop, arr_pop;
  logic [DATASIZE-1:0] rdata;

  assign arr_empty = (wptr_q == rptr_q);
  assign arr_full  = (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]) &&
                     (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]);

  // Decoded from registered pointers only, so out_ready never reaches in_ready.
  assign in_ready = !arr_full;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push)    wptr_d = wptr_q + PTR_ONE;
      if (arr_pop) rptr_d = rptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= AFULL_L);
  assign almost_empty = (count_q <= AEMPTY_L);

  sfifo_mem #(
    .DATASIZE (DATASIZE),
    .DEPTH    (1 << ADDRSIZE),
    .RAM_TYPE (RAM_TYPE)
  ) u_mem (
    .clk      (clk),
    .wclken_i (push && !flush),
    .waddr_i  (wptr_q[ADDRSIZE-1:0]),
    .wdata_i  (in_data),
    .raddr_i  (rptr_q[ADDRSIZE-1:0]),
    .rdata_o  (rdata)
  );

  if (OUT_REG != 0) begin : g_oreg
    logic [DATASIZE-1:0] odata_q, odata_d;
    logic                ovalid_q, ovalid_d;

    // Refill the output register whenever it is free or being drained.
    assign arr_pop = (!ovalid_q || pop) && !arr_empty;

    always_comb begin
      odata_d  = odata_q;
      ovalid_d = ovalid_q;
      if (flush) begin
        ovalid_d = 1'b0;
      end else if (arr_pop) begin
        odata_d  = rdata;
        ovalid_d = 1'b1;
      end else if (pop) begin
        ovalid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        odata_q  <= '0;
        ovalid_q <= 1'b0;
      end else begin
        odata_q  <= odata_d;
        ovalid_q <= ovalid_d;
      end
    end

    assign out_data  = odata_q;
    assign out_valid = ovalid_q;
  end else begin : g_direct
    assign arr_pop   = pop;
    assign out_data  = rdata;
    assign out_valid = !arr_empty;
  end

endmodule

// File: tb/tb_sfifo_stream.sv
module tb_sfifo_stream;

  localparam int DEPTH = 16;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [31:0] od0, od1;
  logic        ov0, ov1, ir0, ir1, af0, af1, ae0, ae1;
  logic [4:0]  cnt0, cnt1;

  sfifo_stream #(.DATASIZE(32), .ADDRSIZE(4), .RAM_TYPE("distributed"), .OUT_REG(0),
                 .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .count(cnt0), .almost_full(af0), .almost_empty(ae0));

  sfifo_stream #(.DATASIZE(32), .ADDRSIZE(4), .RAM_TYPE("distributed"), .OUT_REG(1),
                 .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .count(cnt1), .almost_full(af1), .almost_empty(ae1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: total words held and (OUT_REG=1 only) whether the
  // output register holds one. Data order lives in the scoreboards.
  int          mn [2];
  bit          mov[2];
  logic [31:0] sb0[$];
  logic [31:0] sb1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_arr(input int i);
    return mn[i] - ((i == 1 && mov[i]) ? 1 : 0);
  endfunction

  function automatic bit m_rdy(input int i);
    return m_arr(i) < DEPTH;
  endfunction

  function automatic bit m_ov(input int i);
    return (i == 0) ? (mn[i] > 0) : mov[i];
  endfunction

  task automatic check_state();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready%0d", i),     32'((i == 0) ? ir0 : ir1),   32'(m_rdy(i)));
      chk($sformatf("out_valid%0d", i),    32'((i == 0) ? ov0 : ov1),   32'(m_ov(i)));
      chk($sformatf("count%0d", i),        32'((i == 0) ? cnt0 : cnt1), 32'(mn[i]));
      chk($sformatf("almost_full%0d", i),  32'((i == 0) ? af0 : af1),   32'(mn[i] >= 14));
      chk($sformatf("almost_empty%0d", i), 32'((i == 0) ? ae0 : ae1),   32'(mn[i] <= 2));
    end
  endtask

  task automatic model_step(input int i, input bit iv, input bit ordy, input bit fl,
                            input logic [31:0] d);
    int arr;
    bit ov, push, pop, load;
    ov  = m_ov(i);
    arr = m_arr(i);
    if (fl) begin
      mn[i]  = 0;
      mov[i] = 1'b0;
    end else begin
      push = iv && (arr < DEPTH);
      pop  = ov && ordy;
      if (push) begin
        if (i == 0) sb0.push_back(d);
        else        sb1.push_back(d);
      end
      if (i == 1) begin
        load = (!mov[i] || pop) && (arr > 0);
        if (load)     mov[i] = 1'b1;
        else if (pop) mov[i] = 1'b0;
      end
      mn[i] = mn[i] + int'(push) - int'(pop);
    end
  endtask

  // Called at posedge+2: drive, check registered outputs, advance model, wait one edge.
  task automatic step(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_state();
    model_step(0, iv, ordy, fl, d);
    model_step(1, iv, ordy, fl, d);
    if (fl) begin
      sb0.delete();
      sb1.delete();
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: a pop happens on the coming edge; the head must match the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && out_ready && !flush) begin
      if (ov0) begin
        if (sb0.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop0_unexpected actual=%0h required=none", od0);
        end else begin
          e = sb0.pop_front();
          chk("pop_data0", od0, e);
        end
      end
      if (ov1) begin
        if (sb1.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop1_unexpected actual=%0h required=none", od1);
        end else begin
          e = sb1.pop_front();
          chk("pop_data1", od1, e);
        end
      end
    end
  end

  initial begin
    int bias;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    mn[0] = 0; mn[1] = 0; mov[0] = 1'b0; mov[1] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_in_ready0", 32'(ir0), 1); chk("rst_in_ready1", 32'(ir1), 1);
    chk("rst_out_valid0", 32'(ov0), 0); chk("rst_out_valid1", 32'(ov1), 0);
    chk("rst_count0", 32'(cnt0), 0); chk("rst_count1", 32'(cnt1), 0);
    chk("rst_afull0", 32'(af0), 0); chk("rst_aempty0", 32'(ae0), 1);
    chk("rst_out_data1", od1, 0);

    // Fill with 0x1..0x10 while the consumer stalls.
    for (int k = 1; k <= 16; k++) step(1'b1, 32'(k), 1'b0, 1'b0);
    chk("fill_count0", 32'(cnt0), 16);
    chk("fill_in_ready0", 32'(ir0), 0);
    chk("fill_afull0", 32'(af0), 1);
    chk("fill_in_ready1", 32'(ir1), 1);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    chk("cap17_count1", 32'(cnt1), 17);
    chk("cap17_in_ready1", 32'(ir1), 0);

    // Full with push and pop together: pop wins, push refused.
    step(1'b1, 32'h99, 1'b1, 1'b0);
    chk("fullpop_in_ready0", 32'(ir0), 1);
    chk("fullpop_count0", 32'(cnt0), 15);
    for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_count0", 32'(cnt0), 0);
    chk("drain_count1", 32'(cnt1), 0);

    // Fall-through latency of the output register.
    step(1'b1, 32'hA5, 1'b0, 1'b0);
    chk("a5_ov1_edge1", 32'(ov1), 0);
    chk("a5_ov0_edge1", 32'(ov0), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("a5_ov1_edge2", 32'(ov1), 1);
    chk("a5_data1", od1, 32'hA5);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);

    // Steady streaming at count 5 across pointer wrap.
    for (int k = 0; k < 5; k++) step(1'b1, $urandom(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) step(1'b1, $urandom(), 1'b1, 1'b0);
    chk("stream_count0", 32'(cnt0), 5);
    chk("stream_count1", 32'(cnt1), 5);

    // Flush at count 9 with a push in the same cycle.
    for (int k = 0; k < 4; k++) step(1'b1, $urandom(), 1'b0, 1'b0);
    chk("preflush_count0", 32'(cnt0), 9);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("flush_count0", 32'(cnt0), 0); chk("flush_count1", 32'(cnt1), 0);
    chk("flush_ov0", 32'(ov0), 0);     chk("flush_ov1", 32'(ov1), 0);
    chk("flush_ae0", 32'(ae0), 1);     chk("flush_ae1", 32'(ae1), 1);
    step(1'b1, 32'h1234, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream at count 7.
    for (int k = 0; k < 7; k++) step(1'b1, $urandom(), 1'b0, 1'b0);
    chk("prerst_count0", 32'(cnt0), 7);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_count0", 32'(cnt0), 0); chk("midrst_count1", 32'(cnt1), 0);
    chk("midrst_ov0", 32'(ov0), 0);     chk("midrst_ov1", 32'(ov1), 0);
    chk("midrst_ir0", 32'(ir0), 1);     chk("midrst_ir1", 32'(ir1), 1);
    sb0.delete(); sb1.delete();
    mn[0] = 0; mn[1] = 0; mov[0] = 1'b0; mov[1] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with varying back-pressure and occasional flush.
    for (int k = 0; k < 1600; k++) begin
      bias = ((k / 200) % 2 == 0) ? 25 : 80;
      step($urandom_range(0, 99) < 70, $urandom(), $urandom_range(0, 99) < bias,
           $urandom_range(0, 127) == 0);
    end

    for (int k = 0; k < 60 && (mn[0] != 0 || mn[1] != 0); k++) step(1'b0, '0, 1'b1, 1'b0);
    chk("final_count0", 32'(cnt0), 0);
    chk("final_count1", 32'(cnt1), 0);
    chk("final_sb0_left", 32'(sb0.size()), 0);
    chk("final_sb1_left", 32'(sb1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfifo_stream.md
# sfifo_stream

Single-clock, parametrised stream FIFO with valid/ready handshakes on both sides, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and an optional registered output stage. It wraps a synchronous-write/asynchronous-read RAM array. It sits between leaf-operator pipeline stages that share one clock, where the dual-clock FIFO path is unnecessary.

## Interface
Parameters:
- DATASIZE, 32, data word width
- ADDRSIZE, 4, memory address bits; DEPTH = 2**ADDRSIZE
- RAM_TYPE, "distributed", ram_style attribute applied to the array: "auto", "block" or "distributed"
- OUT_REG, 0, 0 = read straight from the array; 1 = extra output register, first-word-fall-through
- AFULL_LEVEL, DEPTH-2, almost_full asserted when count >= AFULL_LEVEL
- AEMPTY_LEVEL, 2, almost_empty asserted when count <= AEMPTY_LEVEL

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear; has priority over push and pop
- in_data  in  DATASIZE  write data
- in_valid  in  1  write request
- in_ready  out  1  FIFO can accept data; registered
- out_data  out  DATASIZE  head-of-queue data
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts head
- count  out  ADDRSIZE+1  total words held, including the output register
- almost_full  out  1  count >= AFULL_LEVEL
- almost_empty  out  1  count <= AEMPTY_LEVEL

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated on the same edge.
- Write pointer and read pointer are each ADDRSIZE+1 bits. The low ADDRSIZE bits address the array; the MSB is the wrap bit.
  - Array empty: pointers are equal.
  - Array full: low bits are equal and MSBs differ.
  - Pointers wrap modulo 2*DEPTH with no special case.
- OUT_REG=0:
  - out_data = MEM[rptr[ADDRSIZE-1:0]].
  - out_valid = array not empty.
  - Capacity is DEPTH.
- OUT_REG=1:
  - Output register loads the array head whenever (register empty OR pop) AND array not empty.
  - Capacity is DEPTH+1.
- in_ready = !array_full, taken from registered state. There is no combinational path from out_ready to in_ready. When the FIFO is full, a push in the same cycle as a pop is refused, and in_ready rises on the next cycle.
- Array fill: push while the array is full cannot occur. Pop while empty cannot occur, because out_valid is low.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. In OUT_REG=1, count also includes the output register. count never exceeds capacity and is never negative.
- almost_full and almost_empty are decoded from registered count.
- flush: on the next edge, pointers go to 0, count goes to 0 and the output register is emptied. A push in the flush cycle is discarded. Array contents are not cleared.
- Reset values:
  - Pointers and count: 0.
  - out_valid: 0.
  - in_ready: 1.
  - almost_full: 0.
  - almost_empty: 1.
  - out_data: 0 when OUT_REG=1. When OUT_REG=0 it is undefined while out_valid=0, because the array is not reset.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous). Words in flight are lost.

## Timing
- OUT_REG=0: a word pushed at edge k is visible with out_valid=1 after edge k (1-cycle latency). A pop at edge k shows the next word after edge k.
- OUT_REG=1: a word pushed into an empty FIFO at edge k is in the array after k and in the output register after k+1 (2-cycle latency). Back-to-back pops sustain 1 word per cycle.
- Throughput is 1 push and 1 pop per cycle, except the full + pop case above, which costs one bubble.
- in_ready deasserts on the edge where the array becomes full. It reasserts on the edge after the first pop that frees a slot.
- count, almost_full and almost_empty update on the same edge as the push or pop that changes occupancy.

## Structure
- Shared package sfifo_pkg: pointer-width function clog2, and constants for the RAM_TYPE strings.
- One sub-module, sfifo_mem:
  - DATASIZE x DEPTH array, synchronous write (wclken), asynchronous read, ram_style = RAM_TYPE.
  - No reset on the array.
- Top level holds pointers, count, flags, flush logic and the optional output register (generate on OUT_REG).

## Test plan
- Reset, then ADDRSIZE=4, OUT_REG=0, push 0x1..0x10 continuously with out_ready=0:
  - in_ready drops after the 16th push.
  - count=16, almost_full=1 from count 14.
  - Draining returns 0x1..0x10 in order.
- Full FIFO with in_valid=1 and out_ready=1 on the same cycle:
  - The pop succeeds and the push is refused.
  - in_ready=1 on the next cycle and count=15.
- OUT_REG=1: single push of 0xA5 into an empty FIFO:
  - out_valid rises 2 edges later with out_data=0xA5.
  - Capacity test accepts 17 words before in_ready=0.
- Streaming with simultaneous push and pop every cycle at count=5 for 100 cycles:
  - count stays 5.
  - Data order is preserved across pointer wrap (> 2*DEPTH pointer increments).
- flush asserted at count=9 together with in_valid=1:
  - After the edge: count=0, out_valid=0, almost_empty=1.
  - The flushed-cycle word never appears at the output.
- rst_n pulled low mid-stream at count=7, between edges:
  - Outputs immediately show count=0, out_valid=0, in_ready=1.
  - After release, the first push is read back correctly.
